// File: rtl/mips_cpu_control_fsm_if.sv
// -----------------------------------------------------------------------------
// mips_cpu_control_fsm_if
// Bundles the signals between the multicycle control FSM and the datapath /
// memory port.
//   master : the control FSM. It reads the instruction fields, waitrequest and
//            halt_req. It drives the state code, active, the memory strobes,
//            the write strobes and alu_op.
//   slave  : the datapath / memory side, with the opposite directions.
// -----------------------------------------------------------------------------
interface mips_cpu_control_fsm_if;
    logic [5:0] instr_opcode;   // IR[31:26]
    logic [5:0] instr_funct;    // IR[5:0]
    logic [4:0] instr_rt;       // IR[20:16]
    logic       waitrequest;    // memory stall
    logic       halt_req;       // next PC == 0
    logic [2:0] state;          // current state code
    logic       active;         // 1 until HALT
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;   // 0 = PC, 1 = ALU result
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [3:0] alu_op;

    modport master (
        input  instr_opcode, instr_funct, instr_rt, waitrequest, halt_req,
        output state, active, mem_read, mem_write, mem_addr_sel,
               ir_write, pc_write, reg_write, alu_op
    );

    modport slave (
        output instr_opcode, instr_funct, instr_rt, waitrequest, halt_req,
        input  state, active, mem_read, mem_write, mem_addr_sel,
               ir_write, pc_write, reg_write, alu_op
    );
endinterface

// File: rtl/mips_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// mips_cpu_control_fsm
// Multicycle main control for the MIPS CPU. Each instruction is sequenced as
// FETCH -> DECODE -> EXEC -> [MEM] -> WB. FETCH and MEM stall on waitrequest.
// WB enters HALT when the datapath reports a jump to address 0.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : control/datapath bundle (master side), see mips_cpu_control_fsm_if
// Only the state register is sequential. Every output decodes combinationally
// from the state and the instruction fields.
// -----------------------------------------------------------------------------
module mips_cpu_control_fsm (
    input  logic                          clk,
    input  logic                          reset,
    mips_cpu_control_fsm_if.master        bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_rw_en;
    logic       w_active;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_addr_sel;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic [3:0] w_alu_op;
    logic       w_unused_rt;

    // Only rt[4] matters: it selects the linking REGIMM branches.
    assign w_unused_rt = ^bus.instr_rt[3:0];

    assign w_is_load  = bus.instr_opcode inside {6'b100000, 6'b100001, 6'b100010,
                                                 6'b100011, 6'b100100, 6'b100101,
                                                 6'b100110};
    assign w_is_store = bus.instr_opcode inside {6'b101000, 6'b101001, 6'b101011};

    // Register file write is needed for:
    //   - R-type except jr
    //   - immediate ALU ops
    //   - loads
    //   - jal
    //   - linking REGIMM branches
    assign w_rw_en = ((bus.instr_opcode == 6'b000000) && (bus.instr_funct != 6'b001000))
                   || (bus.instr_opcode inside {6'b001001, 6'b001010, 6'b001011,
                                                6'b001100, 6'b001101, 6'b001110,
                                                6'b001111})
                   || w_is_load
                   || (bus.instr_opcode == 6'b000011)
                   || ((bus.instr_opcode == 6'b000001) && bus.instr_rt[4]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_active       = 1'b1;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_reg_write    = 1'b0;
        w_alu_op       = 4'b0000;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (!bus.waitrequest) begin
                    w_ir_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                case (bus.instr_opcode)
                    6'b000000: w_alu_op = 4'b0010;
                    6'b000100: w_alu_op = 4'b0001;
                    6'b000101: w_alu_op = 4'b1000;
                    6'b000111: w_alu_op = 4'b1001;
                    6'b000110: w_alu_op = 4'b1010;
                    6'b000001: w_alu_op = 4'b1011;
                    6'b001001: w_alu_op = 4'b0011;
                    6'b001100: w_alu_op = 4'b0100;
                    6'b001101: w_alu_op = 4'b0101;
                    6'b001110: w_alu_op = 4'b0110;
                    6'b001011: w_alu_op = 4'b0111;
                    default:   w_alu_op = 4'b0000;  // loads/stores add offsets
                endcase
                w_next_state = (w_is_load || w_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // Strobes depend only on the opcode, so they are held steady
                // through a stall.
                w_mem_addr_sel = 1'b1;
                w_mem_read     = w_is_load;
                w_mem_write    = w_is_store;
                if (!bus.waitrequest) begin
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                w_pc_write   = 1'b1;
                w_reg_write  = w_rw_en;
                w_next_state = bus.halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                w_active = 1'b0;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        // No side effects may escape while reset is being applied.
        if (reset) begin
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_pc_write  = 1'b0;
            w_reg_write = 1'b0;
        end
    end

    assign bus.state        = r_state;
    assign bus.active       = w_active;
    assign bus.mem_read     = w_mem_read;
    assign bus.mem_write    = w_mem_write;
    assign bus.mem_addr_sel = w_mem_addr_sel;
    assign bus.ir_write     = w_ir_write;
    assign bus.pc_write     = w_pc_write;
    assign bus.reg_write    = w_reg_write;
    assign bus.alu_op       = w_alu_op;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
module tb_mips_cpu_control_fsm;

    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    int    n_cmp  = 0;
    int    n_fail = 0;
    string cur_instr = "init";

    mips_cpu_control_fsm_if bus ();

    mips_cpu_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference rules ----------------
    function automatic bit ref_load(input logic [5:0] op);
        logic [5:0] lds [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
        foreach (lds[k]) if (lds[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    function automatic logic [3:0] ref_alu(input logic [5:0] op);
        logic [5:0] ops [11] = '{6'o00, 6'o04, 6'o05, 6'o07, 6'o06, 6'o01,
                                 6'o11, 6'o14, 6'o15, 6'o16, 6'o13};
        logic [3:0] res [11] = '{4'd2, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11,
                                 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        foreach (ops[k]) if (ops[k] == op) return res[k];
        return 4'd0;
    endfunction

    function automatic bit ref_regwr(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt);
        if (op == 6'o00) return fn != 6'o10;
        if (op >= 6'o11 && op <= 6'o17) return 1'b1;
        if (ref_load(op)) return 1'b1;
        if (op == 6'o03) return 1'b1;
        if (op == 6'o01) return rt[4];
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs after the falling edge, then compare the
    // combinational outputs 1 ns later, well away from the rising edge.
    task automatic cyc(input bit rst, input bit wr, input bit hr,
                       input logic [2:0] st, input bit act, input bit mr, input bit mw,
                       input bit irw, input bit pcw, input bit rw, input logic [3:0] alu,
                       input bit chk_sel, input bit sel, input string phase);
        logic [12:0] obs, expv;
        @(negedge clk);
        reset           = rst;
        bus.waitrequest = wr;
        bus.halt_req    = hr;
        #1;
        obs  = {bus.state, bus.active, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.pc_write, bus.reg_write, bus.alu_op};
        expv = {st, act, mr, mw, irw, pcw, rw, alu};
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s {st,act,mr,mw,irw,pcw,rw,alu} observed=%b expected=%b",
                   cur_instr, phase, obs, expv);
        end
        if (chk_sel) begin
            n_cmp++;
            assert (bus.mem_addr_sel === sel) else begin
                n_fail++;
                $error("FAIL %s/%s mem_addr_sel observed=%b expected=%b",
                       cur_instr, phase, bus.mem_addr_sel, sel);
            end
        end
    endtask

    // Walk one instruction through the control sequence, cycle by cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] rt, input int fst, input int mst,
                             input bit hreq, input bit rst_mem, input string name);
        bit ld, stv, rw;
        cur_instr        = name;
        bus.instr_opcode = op;
        bus.instr_funct  = fn;
        bus.instr_rt     = rt;
        ld  = ref_load(op);
        stv = ref_store(op);
        rw  = ref_regwr(op, fn, rt);
        for (int i = 0; i <= fst; i++)
            cyc(0, i < fst, 1'($urandom), 3'd0, 1, 1, 0, i == fst, 0, 0, 4'd0, 1, 0, "fetch");
        cyc(0, 1'($urandom), 1'($urandom), 3'd1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, "decode");
        cyc(0, 1'($urandom), 1'($urandom), 3'd2, 1, 0, 0, 0, 0, 0, ref_alu(op), 0, 0, "exec");
        if (ld || stv) begin
            for (int i = 0; i <= mst; i++) begin
                if (rst_mem && i == 1) begin
                    cyc(1, 1, 1'($urandom), 3'd3, 1, 0, 0, 0, 0, 0, 4'd0, 1, 1, "mem_reset");
                    cyc(0, 1, 1'($urandom), 3'd0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, "after_reset");
                    return;
                end
                cyc(0, i < mst, 1'($urandom), 3'd3, 1, ld, stv, 0, 0, 0, 4'd0, 1, 1, "mem");
            end
        end
        cyc(0, 1'($urandom), hreq, 3'd4, 1, 0, 0, 0, 1, rw, 4'd0, 0, 0, "wb");
        if (hreq)
            for (int i = 0; i < 10; i++)
                cyc(0, 1'($urandom), 1'($urandom), 3'd5, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, "halt");
    endtask

    initial begin
        logic [5:0] pool [20] = '{6'o00, 6'o01, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07,
                                  6'o11, 6'o12, 6'o13, 6'o14, 6'o15, 6'o16, 6'o17,
                                  6'h20, 6'h23, 6'h25, 6'h28, 6'h29, 6'h2B};
        logic [5:0] op, fn;
        bus.waitrequest  = 1'b0;
        bus.halt_req     = 1'b0;
        bus.instr_opcode = 6'd0;
        bus.instr_funct  = 6'd0;
        bus.instr_rt     = 5'd0;
        repeat (2) @(posedge clk);
        cur_instr = "reset";
        cyc(1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 4'd0, 1, 0, "held");

        run_instr(6'o11, 6'd0,     5'd0,      0, 0, 0, 0, "addiu");
        run_instr(6'h23, 6'd0,     5'd0,      0, 3, 0, 0, "lw");
        run_instr(6'h2B, 6'd0,     5'd0,      1, 1, 0, 0, "sw");
        run_instr(6'o04, 6'd0,     5'd0,      0, 0, 0, 0, "beq");
        run_instr(6'o01, 6'd0,     5'b10001,  0, 0, 0, 0, "bgezal");
        run_instr(6'o01, 6'd0,     5'b00001,  0, 0, 0, 0, "bgez");
        run_instr(6'o00, 6'o10,    5'd0,      0, 0, 0, 0, "jr");
        run_instr(6'o00, 6'h21,    5'd0,      2, 0, 0, 0, "addu");

        for (int n = 0; n < 40; n++) begin
            op = ($urandom % 2) ? pool[$urandom % 20] : 6'($urandom);
            fn = ($urandom % 4 == 0) ? 6'o10 : 6'($urandom);
            run_instr(op, fn, 5'($urandom), $urandom % 3, $urandom % 4, 0, 0,
                      $sformatf("rand%0d_op%0o", n, op));
        end

        run_instr(6'o00, 6'o10, 5'd0, 0, 0, 1, 0, "jr_halt");
        cur_instr = "halt_reset";
        cyc(1, 0, 0, 3'd5, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, "held");
        run_instr(6'o11, 6'd0, 5'd0, 0, 0, 0, 0, "addiu_after_halt");

        run_instr(6'h23, 6'd0, 5'd0, 0, 3, 0, 1, "lw_reset_mid_stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_cpu_control_fsm.md
Name: mips_cpu_control_fsm

Overview:
- Multicycle main control state machine for the MIPS CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback over an Avalon-style memory port with waitrequest stalls.
- Drives the 4-bit ALUOp consumed by the ALU control stage, plus the datapath write strobes.
- Asserts halt when the datapath signals a jump to address 0.

Parameters:
- None. State encoding is fixed: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- instr_opcode  in  6  IR[31:26], valid from DECODE onward
- instr_funct  in  6  IR[5:0]
- instr_rt  in  5  IR[20:16], used for REGIMM link decode
- waitrequest  in  1  memory stall; transfer completes in a cycle where it is 0
- halt_req  in  1  datapath: next PC == 0x00000000
- state  out  3  current state code
- active  out  1  1 until HALT entered
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  latch instruction register
- pc_write  out  1  commit next PC
- reg_write  out  1  register file write enable
- alu_op  out  4  ALUOp to the ALU control stage

Behaviour:
- Only the state register is sequential. All other outputs decode combinationally from state and the instruction fields.

Reset:
- reset=1 at a rising edge sets state to FETCH, from any state including HALT and mid-stall.
- While reset=1, mem_read, mem_write, ir_write, pc_write and reg_write are forced to 0.
- First cycle after reset: state=0, active=1, mem_read=1, mem_addr_sel=0, alu_op=0000.

State transitions:
- FETCH:
  - Outputs: mem_read=1, mem_addr_sel=0.
  - Stays in FETCH while waitrequest=1.
  - When waitrequest=0: ir_write=1 in that cycle, next state DECODE.
- DECODE:
  - One cycle, no strobes.
  - Next state EXEC.
- EXEC:
  - One cycle; alu_op is decoded from instr_opcode (table below).
  - Load or store opcodes go to MEM; all others go to WB.
- MEM:
  - Outputs: mem_addr_sel=1.
  - Loads (100000, 100001, 100010, 100011, 100100, 100101, 100110) drive mem_read=1.
  - Stores (101000, 101001, 101011) drive mem_write=1.
  - Stays in MEM while waitrequest=1; strobes are held stable during the stall.
  - When waitrequest=0, next state WB.
- WB:
  - One cycle; pc_write=1.
  - reg_write=1 for:
    - R-type (000000) except funct 001000 (jr)
    - opcodes 001001, 001010, 001011, 001100, 001101, 001110, 001111
    - all loads
    - jal (000011)
    - REGIMM (000001) with instr_rt[4]=1
  - reg_write=0 otherwise.
  - Next state HALT if halt_req=1, else FETCH.
- HALT:
  - active=0, all strobes 0, alu_op=0000.
  - Stays in HALT until reset.
- Unused state codes 6 and 7 go to FETCH on the next edge, with all strobes 0.

alu_op decode in EXEC (alu_op=0000 in every other state):
- 000000 → 0010
- loads/stores → 0000
- 000100 → 0001
- 000101 → 1000
- 000111 → 1001
- 000110 → 1010
- 000001 → 1011
- 001001 → 0011
- 001100 → 0100
- 001101 → 0101
- 001110 → 0110
- 001011 → 0111
- any other opcode → 0000

Latency and ordering:
- Minimum latency is 4 cycles for non-memory instructions and 5 for loads/stores, plus one cycle per waitrequest=1 cycle.
- mem_read and mem_write are never asserted together.
- ir_write and reg_write are never asserted in the same cycle.

Test Plan:
- Reset pulse, then addiu (opcode 001001), waitrequest=0: states 0,1,2,4,0; ir_write in cycle 0; alu_op=0011 in EXEC; reg_write=1 and pc_write=1 in WB.
- lw (100011), waitrequest=1 for 3 cycles in MEM: MEM lasts 4 cycles with mem_read=1 and mem_addr_sel=1 throughout; WB has reg_write=1.
- sw (101011) then beq (000100): sw MEM has mem_write=1 and reg_write=0 in WB; beq has alu_op=0001 in EXEC and reg_write=0.
- REGIMM with rt=10001 versus rt=00001: alu_op=1011 for both; reg_write=1 only for 10001. R-type jr (funct 001000) gives reg_write=0.
- jr with halt_req=1 in WB: state goes to 5, active=0, strobes stay 0 for 10 cycles; reset then returns to FETCH with active=1.
- reset asserted in MEM mid-stall: mem_read forced to 0 in that cycle; state=0 next cycle, mem_addr_sel=0.
